rv_m_unit: RTL and testbench



---
 rtl/rv_m_unit.sv | 186 ++++++++++++++++++
 tb/tb_rv_m_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_m_unit.sv
// rv_m_unit: RV-M execute-stage unit. Pipelined multiplier, iterative
// restoring divider (DIV_BITS quotient bits per cycle) with a fast path for
// divide-by-zero / signed overflow, and a one-entry quotient/remainder cache.
module rv_m_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int DIV_BITS   = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic            i_kill,
    input  logic [2:0]      i_f3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic [XLEN-1:0] o_res,
    output logic            o_stall
);
    localparam int N  = XLEN / DIV_BITS;
    localparam int CW = $clog2(N);
    localparam int MS = (MUL_STAGES == 0) ? 1 : MUL_STAGES;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MUL_WAIT = 2'd1;
    localparam logic [1:0] S_DIV_RUN  = 2'd2;
    localparam logic [1:0] S_DIV_FIX  = 2'd3;

    localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      r_state;
    logic [MS-1:0]   r_mvld;
    logic [XLEN-1:0] r_quo, r_rem, r_dvs;
    logic            r_qneg, r_rneg;
    logic [CW-1:0]   r_cnt;
    logic            r_cv, r_cu;
    logic [XLEN-1:0] r_ca, r_cb, r_cq, r_cr;

    logic              w_kill, w_sdiv, w_hit, w_dz, w_ovf;
    logic              w_sa, w_sb, w_mul_issue, w_mul_done;
    logic [XLEN-1:0]   w_abs1, w_abs2, w_fq, w_fr, w_step_q, w_step_r, w_mres;
    logic [2*XLEN-1:0] w_ma, w_mb, w_prod, w_pout;

    // Dropping i_en mid-operation aborts exactly like an explicit kill.
    assign w_kill = i_kill | (~i_en & (r_state != S_IDLE));

    // Multiplier operands are sign/zero-extended to 2*XLEN so one unsigned
    // multiply covers all four signedness combinations.
    assign w_sa   = (i_f3[1:0] != 2'b11);
    assign w_sb   = ~i_f3[1];
    assign w_ma   = {{XLEN{w_sa & i_rs1[XLEN-1]}}, i_rs1};
    assign w_mb   = {{XLEN{w_sb & i_rs2[XLEN-1]}}, i_rs2};
    assign w_prod = w_ma * w_mb;

    generate
        if (MUL_STAGES == 0) begin : g_mul_comb
            assign w_pout = w_prod;
        end else begin : g_mul_pipe
            logic [2*XLEN-1:0] r_mp [MUL_STAGES];
            // Product pipeline; data is qualified by r_mvld so it carries no reset.
            always_ff @(posedge i_clk) begin
                r_mp[0] <= w_prod;
                for (int s = 1; s < MUL_STAGES; s++) r_mp[s] <= r_mp[s-1];
            end
            assign w_pout = r_mp[MUL_STAGES-1];
        end
    endgenerate

    assign w_mres      = (i_f3[1:0] == 2'b00) ? w_pout[XLEN-1:0] : w_pout[2*XLEN-1:XLEN];
    assign w_mul_issue = (r_state == S_IDLE) & i_en & ~i_f3[2] & (MUL_STAGES != 0);
    assign w_mul_done  = (MUL_STAGES == 0) ? 1'b1 : r_mvld[MS-1];

    // Divider operand conditioning and special-case detection.
    assign w_sdiv = ~i_f3[0];
    assign w_abs1 = (w_sdiv & i_rs1[XLEN-1]) ? -i_rs1 : i_rs1;
    assign w_abs2 = (w_sdiv & i_rs2[XLEN-1]) ? -i_rs2 : i_rs2;
    assign w_dz   = (i_rs2 == '0);
    assign w_ovf  = w_sdiv & (i_rs1 == MINV) & (&i_rs2);
    assign w_hit  = i_f3[2] & r_cv & (r_ca == i_rs1) & (r_cb == i_rs2) & (r_cu == i_f3[0]);

    // DIV_BITS restoring steps per cycle; r_quo shifts the dividend out at
    // the top while quotient bits enter at the bottom.
    always_comb begin
        logic [XLEN:0]   t_r;
        logic [XLEN-1:0] t_q;
        t_r = {1'b0, r_rem};
        t_q = r_quo;
        for (int k = 0; k < DIV_BITS; k++) begin
            t_r = {t_r[XLEN-1:0], t_q[XLEN-1]};
            t_q = {t_q[XLEN-2:0], 1'b0};
            if (t_r >= {1'b0, r_dvs}) begin
                t_r    = t_r - {1'b0, r_dvs};
                t_q[0] = 1'b1;
            end
        end
        w_step_q = t_q;
        w_step_r = t_r[XLEN-1:0];
    end

    // Fast-path results are stored already final with both sign flags clear.
    assign w_fq = r_qneg ? -r_quo : r_quo;
    assign w_fr = r_rneg ? -r_rem : r_rem;

    // Stall and result; reset, kill and idle all force both to zero.
    always_comb begin
        o_stall = 1'b0;
        o_res   = '0;
        if (i_rst && i_en && !w_kill) begin
            case (r_state)
                S_IDLE: begin
                    if (!i_f3[2]) begin
                        if (MUL_STAGES == 0) o_res = w_mres;
                        else                 o_stall = 1'b1;
                    end else if (w_hit) begin
                        o_res = i_f3[1] ? r_cr : r_cq;
                    end else begin
                        o_stall = 1'b1;
                    end
                end
                S_MUL_WAIT: begin
                    if (w_mul_done) o_res = w_mres;
                    else            o_stall = 1'b1;
                end
                S_DIV_RUN: o_stall = 1'b1;
                default:   o_res = i_f3[1] ? w_fr : w_fq;
            endcase
        end
    end

    // Control FSM, multiplier valid pipe, divider datapath and result cache.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
            r_mvld  <= '0;
            r_cv    <= 1'b0;
        end else if (w_kill) begin
            r_state <= S_IDLE;
            r_mvld  <= '0;
            if (r_state == S_DIV_RUN || r_state == S_DIV_FIX) r_cv <= 1'b0;
        end else begin
            r_mvld <= (r_mvld << 1) | MS'(w_mul_issue);
            case (r_state)
                S_IDLE: begin
                    if (i_en) begin
                        if (!i_f3[2]) begin
                            if (MUL_STAGES != 0) r_state <= S_MUL_WAIT;
                        end else if (!w_hit) begin
                            if (w_dz || w_ovf) begin
                                r_quo   <= w_dz ? '1 : i_rs1;
                                r_rem   <= w_dz ? i_rs1 : '0;
                                r_qneg  <= 1'b0;
                                r_rneg  <= 1'b0;
                                r_state <= S_DIV_FIX;
                            end else begin
                                r_quo   <= w_abs1;
                                r_rem   <= '0;
                                r_dvs   <= w_abs2;
                                r_qneg  <= w_sdiv & (i_rs1[XLEN-1] ^ i_rs2[XLEN-1]);
                                r_rneg  <= w_sdiv & i_rs1[XLEN-1];
                                r_cnt   <= '0;
                                r_state <= S_DIV_RUN;
                            end
                        end
                    end
                end
                S_MUL_WAIT: begin
                    if (w_mul_done) r_state <= S_IDLE;
                end
                S_DIV_RUN: begin
                    r_quo <= w_step_q;
                    r_rem <= w_step_r;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N-1)) r_state <= S_DIV_FIX;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cv    <= 1'b1;
                    r_ca    <= i_rs1;
                    r_cb    <= i_rs2;
                    r_cu    <= i_f3[0];
                    r_cq    <= w_fq;
                    r_cr    <= w_fr;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rv_m_unit.sv
// tb_rv_m_unit: directed vector table and hand sequences on a 32-bit
// instance (MUL_STAGES=2, DIV_BITS=2), plus directed and random checks
// against a reference model on a 64-bit instance (MUL_STAGES=0, DIV_BITS=4).
module tb_rv_m_unit;
    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, kill, stall;
    logic [2:0]  f3;
    logic [31:0] a, b, res;
    logic        en64, kill64, stall64;
    logic [2:0]  f364;
    logic [63:0] a64, b64, res64;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    // free-running cycle counter for relative timing checks
    always @(posedge clk) cyc <= cyc + 1;

    rv_m_unit #(.XLEN(32), .MUL_STAGES(2), .DIV_BITS(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_kill(kill), .i_f3(f3),
        .i_rs1(a), .i_rs2(b), .o_res(res), .o_stall(stall));

    rv_m_unit #(.XLEN(64), .MUL_STAGES(0), .DIV_BITS(4)) dut64 (
        .i_clk(clk), .i_rst(rst), .i_en(en64), .i_kill(kill64), .i_f3(f364),
        .i_rs1(a64), .i_rs2(b64), .o_res(res64), .o_stall(stall64));

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a, b, res;
        int          lat;
        string       nm;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic [2:0] op, input logic [31:0] x, y, r,
                                input int l, input string nm);
        vec_t v;
        v.f3 = op; v.a = x; v.b = y; v.res = r; v.lat = l; v.nm = nm;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run32(input logic [2:0] op, input logic [31:0] x, y, er,
                         input int el, input string nm, output int done);
        int c;
        c = 0;
        en = 1'b1; kill = 1'b0; f3 = op; a = x; b = y;
        @(negedge clk);
        while (stall && c < 40) begin
            @(posedge clk); #1; c++; @(negedge clk);
        end
        chk({nm, " latency"}, 64'(c), 64'(el));
        chk({nm, " result"}, 64'(res), 64'(er));
        done = cyc;
        @(posedge clk); #1;
    endtask

    task automatic run64(input logic [2:0] op, input logic [63:0] x, y, er,
                         input int el, input string nm);
        int c;
        c = 0;
        en64 = 1'b1; kill64 = 1'b0; f364 = op; a64 = x; b64 = y;
        @(negedge clk);
        while (stall64 && c < 40) begin
            @(posedge clk); #1; c++; @(negedge clk);
        end
        chk({nm, " latency"}, 64'(c), 64'(el));
        chk({nm, " result"}, res64, er);
        @(posedge clk); #1;
    endtask

    // issue an op on the 32-bit unit, expect stall for kc cycles, then kill it
    task automatic issue_kill(input logic [2:0] op, input logic [31:0] x, y,
                              input int kc, input string nm);
        en = 1'b1; kill = 1'b0; f3 = op; a = x; b = y;
        for (int i = 0; i < kc; i++) begin
            @(negedge clk); chk({nm, " stall"}, 64'(stall), 64'd1);
            @(posedge clk); #1;
        end
        kill = 1'b1;
        @(negedge clk);
        chk({nm, " kill stall"}, 64'(stall), 64'd0);
        chk({nm, " kill result"}, 64'(res), 64'd0);
        @(posedge clk); #1;
        kill = 1'b0;
    endtask

    function automatic logic [63:0] gmul(input logic [2:0] op, input logic [63:0] x, y);
        logic signed [127:0] sx, sy;
        logic [127:0] ux, uy, p;
        sx = 128'($signed(x));
        sy = 128'($signed(y));
        ux = {64'd0, x};
        uy = {64'd0, y};
        case (op[1:0])
            2'b01:   p = sx * sy;
            2'b10:   p = sx * $signed(uy);
            default: p = ux * uy;
        endcase
        return (op[1:0] == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    function automatic logic [63:0] gdiv(input logic [2:0] op, input logic [63:0] x, y);
        logic [63:0] q, r;
        if (y == 64'd0) begin
            q = '1; r = x;
        end else if (!op[0] && x == MIN64 && y == '1) begin
            q = x; r = 64'd0;
        end else if (op[0]) begin
            q = x / y; r = x % y;
        end else begin
            q = $signed(x) / $signed(y); r = $signed(x) % $signed(y);
        end
        return op[1] ? r : q;
    endfunction

    function automatic logic [63:0] pick(input logic [63:0] prev);
        case ($urandom_range(0, 6))
            0:       return {$urandom, $urandom};
            1:       return 64'($urandom_range(0, 20));
            2:       return 64'd0 - 64'($urandom_range(1, 20));
            3:       return 64'd0;
            4:       return MIN64;
            5:       return '1;
            default: return prev;
        endcase
    endfunction

    initial begin
        int d [16];
        int dn;
        logic        mcv, mcu;
        logic [63:0] mca, mcb, px, py;

        rst = 1'b0; en = 1'b1; kill = 1'b0; f3 = DIV; a = 32'd100; b = 32'd3;
        en64 = 1'b1; kill64 = 1'b0; f364 = MUL; a64 = 64'd5; b64 = 64'd6;
        @(negedge clk);
        chk("reset stall", 64'(stall), 64'd0);
        chk("reset result", 64'(res), 64'd0);
        chk("reset stall64", 64'(stall64), 64'd0);
        chk("reset result64", res64, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1; en = 1'b0; en64 = 1'b0;
        @(negedge clk);
        chk("idle stall", 64'(stall), 64'd0);
        chk("idle result", 64'(res), 64'd0);
        @(posedge clk); #1;

        tv.push_back(mk(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, "mulh min*min"));
        tv.push_back(mk(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, "mulhsu -1*max"));
        tv.push_back(mk(MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 2, "mul 7*-3"));
        tv.push_back(mk(MUL,    32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 2, "mul b2b"));
        tv.push_back(mk(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, "mulhu max*max"));
        tv.push_back(mk(DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 17, "div -7/2"));
        tv.push_back(mk(REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0, "rem -7/2 hit"));
        tv.push_back(mk(DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, 1, "divu x/0"));
        tv.push_back(mk(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div ovf"));
        tv.push_back(mk(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0, "rem ovf hit"));
        tv.push_back(mk(REMU,   32'd100,       32'd0,         32'd100,       1, "remu x/0"));
        tv.push_back(mk(DIV,    32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 17, "div 100/-7"));
        tv.push_back(mk(REM,    32'd100,       32'hFFFF_FFF9, 32'd2,         0, "rem 100/-7 hit"));
        tv.push_back(mk(DIVU,   32'hFFFF_FFFF, 32'd3,         32'h5555_5555, 17, "divu max/3"));
        tv.push_back(mk(MUL,    32'd3,         32'd5,         32'd15,        2, "mul between"));
        tv.push_back(mk(REMU,   32'hFFFF_FFFF, 32'd3,         32'd0,         0, "remu hit after mul"));

        for (int i = 0; i < tv.size(); i++)
            run32(tv[i].f3, tv[i].a, tv[i].b, tv[i].res, tv[i].lat, tv[i].nm, d[i]);
        chk("mul back-to-back spacing", 64'(d[3] - d[2]), 64'd3);

        // kill mid-divide drops the cached 1000/7 pair
        run32(DIVU, 32'd1000, 32'd7, 32'd142, 17, "divu 1000/7", dn);
        issue_kill(DIVU, 32'd2000, 32'd7, 5, "kill div");
        run32(REMU, 32'd1000, 32'd7, 32'd6, 17, "remu after div kill", dn);
        // kill during MUL_WAIT keeps the cache
        issue_kill(MUL, 32'd3, 32'd3, 1, "kill mul");
        run32(DIVU, 32'd1000, 32'd7, 32'd142, 0, "divu hit after mul kill", dn);

        // dropping i_en mid-divide acts as a kill
        en = 1'b1; f3 = DIVU; a = 32'd2000; b = 32'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("en-drop pre stall", 64'(stall), 64'd1);
            @(posedge clk); #1;
        end
        en = 1'b0;
        @(negedge clk);
        chk("en-drop stall", 64'(stall), 64'd0);
        chk("en-drop result", 64'(res), 64'd0);
        @(posedge clk); #1;
        run32(REMU, 32'd1000, 32'd7, 32'd6, 17, "remu after en drop", dn);

        // synchronous reset in the middle of a divide
        en = 1'b1; f3 = DIV; a = 32'd5000; b = 32'd3;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); chk("pre-reset stall", 64'(stall), 64'd1);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("mid-op reset stall", 64'(stall), 64'd0);
        chk("mid-op reset result", 64'(res), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        run32(REMU, 32'd1000, 32'd7, 32'd6, 17, "remu after reset", dn);
        run32(DIV, 32'd5000, 32'd3, 32'd1666, 17, "div repeat after reset", dn);
        en = 1'b0;

        // 64-bit configuration: combinational multiply, 4-bit divide steps
        run64(MUL,   '1, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 0, "mul64 comb");
        run64(MULHU, '1, 64'd3, 64'd2, 0, "mulhu64 comb");
        run64(DIV,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 17, "div64 -100/7");
        run64(REM,   64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 0, "rem64 hit");

        mcv = 1'b1; mcu = 1'b0; mca = 64'hFFFF_FFFF_FFFF_FF9C; mcb = 64'd7;
        px = mca; py = mcb;
        for (int n = 0; n < 2000; n++) begin
            logic [2:0]  op;
            logic [63:0] x, y, er;
            logic        isdiv, hit, spec;
            int          el, kc;
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                x = px; y = py;
            end else begin
                x = pick(px); y = pick(py);
            end
            isdiv = op[2];
            spec  = (y == 64'd0) || (!op[0] && x == MIN64 && y == '1);
            hit   = isdiv && mcv && mca == x && mcb == y && mcu == op[0];
            er    = isdiv ? gdiv(op, x, y) : gmul(op, x, y);
            el    = !isdiv ? 0 : hit ? 0 : spec ? 1 : 17;
            kc    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, el)) : -1;
            if (kc >= 0) begin
                en64 = 1'b1; kill64 = 1'b0; f364 = op; a64 = x; b64 = y;
                for (int i = 0; i < kc; i++) begin
                    @(negedge clk); chk("rnd pre-kill stall", 64'(stall64), 64'd1);
                    @(posedge clk); #1;
                end
                kill64 = 1'b1;
                @(negedge clk);
                chk("rnd kill stall", 64'(stall64), 64'd0);
                chk("rnd kill result", res64, 64'd0);
                @(posedge clk); #1;
                kill64 = 1'b0;
                if (isdiv && !hit && kc >= 1) mcv = 1'b0;
            end else begin
                run64(op, x, y, er, el, "rnd op");
                if (isdiv && !hit) begin
                    mcv = 1'b1; mca = x; mcb = y; mcu = op[0];
                end
            end
            px = x; py = y;
        end
        en64 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
